// File: rtl/spart_boot_loader.sv
// rtl/spart_boot_loader.sv - SPART serial boot loader: length/payload/checksum protocol into instruction memory
// A load is armed by start; the CPU read port is blocked while busy.
module spart_boot_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR} state_t;

  state_t                r_state;
  logic [15:0]           r_len;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [1:0]            r_byte_cnt;
  logic [7:0]            r_csum;
  logic [TW-1:0]         r_timer;
  logic [ADDR_WIDTH:0]   r_words;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] w_word;
  logic [15:0]           w_len;
  logic                  w_last_byte;
  logic                  w_we;

  assign w_word      = (r_asm << 8) | DATA_WIDTH'(rx_data);
  assign w_len       = {r_len[15:8], rx_data};
  assign w_last_byte = (r_byte_cnt == 2'(BYTES - 1));
  assign w_we        = !rst && (r_state == DATA) && rx_valid && w_last_byte;

  assign rd_data      = r_rd_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

  // Memory has no reset so a previously loaded image survives rst.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_words[ADDR_WIDTH-1:0]] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else if (rd_en && !r_busy) r_rd_data <= r_mem[rd_addr];
    else r_rd_data <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
      r_timer    <= '0;
      r_words    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= LEN_HI;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_words    <= '0;
            r_csum     <= '0;
            r_timer    <= '0;
            r_byte_cnt <= '0;
          end
        end
        default: begin
          if (rx_valid) begin
            r_timer <= '0;
            case (r_state)
              LEN_HI: begin
                r_len[15:8] <= rx_data;
                r_state     <= LEN_LO;
              end
              LEN_LO: begin
                r_len[7:0] <= rx_data;
                if (32'(w_len) > 32'(DEPTH)) begin
                  r_state <= ERR;
                  r_busy  <= 1'b0;
                  r_error <= 1'b1;
                end else if (w_len == 16'd0) begin
                  r_state <= CHECK;
                end else begin
                  r_state <= DATA;
                end
              end
              DATA: begin
                r_csum <= r_csum ^ rx_data;
                r_asm  <= w_word;
                if (w_last_byte) begin
                  r_byte_cnt <= '0;
                  r_words    <= r_words + 1'b1;
                  if (32'(r_words) + 32'd1 == 32'(r_len)) r_state <= CHECK;
                end else begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                end
              end
              CHECK: begin
                r_busy <= 1'b0;
                if (rx_data == r_csum) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ERR;
                  r_error <= 1'b1;
                end
              end
              default: r_state <= IDLE;
            endcase
          end else if (32'(r_timer) == 32'(TIMEOUT - 1)) begin
            r_state <= ERR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_boot_loader.sv
// tb/tb_spart_boot_loader.sv - directed self-checking bench for spart_boot_loader
module tb_spart_boot_loader;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  spart_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0; rx_data = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk); rd_en = 1'b1; rd_addr = a;
    @(negedge clk); rd_en = 1'b0; d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
    n_tests++; if (words_loaded !== 5'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_loaded); end
    n_tests++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
  endtask

  task automatic test_nominal();
    logic [DW-1:0] d;
    pulse_start();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy got %b want 1", busy); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    // 12 ^ 34 ^ AB ^ CD = 40
    send_byte(8'h40);
    n_tests++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nom_flags got done=%b error=%b busy=%b want 1 0 0", done, error, busy); end
    n_tests++; if (words_loaded !== 5'd2) begin n_fail++; $display("FAIL nom_words got %0d want 2", words_loaded); end
    do_read(4'd0, d);
    n_tests++; if (d !== 16'h1234) begin n_fail++; $display("FAIL nom_rd0 got %h want 1234", d); end
    do_read(4'd1, d);
    n_tests++; if (d !== 16'hABCD) begin n_fail++; $display("FAIL nom_rd1 got %h want abcd", d); end
    @(negedge clk);
    n_tests++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL nom_rd_idle got %h want 0000", rd_data); end
  endtask

  task automatic test_bad_checksum();
    logic [DW-1:0] d;
    pulse_start();
    n_tests++; if (done !== 1'b0 || words_loaded !== 5'd0) begin
      n_fail++; $display("FAIL bad_start_clear got done=%b words=%0d want 0 0", done, words_loaded); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC);
    send_byte(8'h00);
    n_tests++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_flags got error=%b done=%b busy=%b want 1 0 0", error, done, busy); end
    n_tests++; if (words_loaded !== 5'd2) begin n_fail++; $display("FAIL bad_words got %0d want 2", words_loaded); end
    do_read(4'd0, d);
    n_tests++; if (d !== 16'h5678) begin n_fail++; $display("FAIL bad_rd0 got %h want 5678", d); end
    do_read(4'd1, d);
    n_tests++; if (d !== 16'h9ABC) begin n_fail++; $display("FAIL bad_rd1 got %h want 9abc", d); end
  endtask

  task automatic test_oversize();
    logic [DW-1:0] d;
    pulse_start();
    send_byte(8'h00); send_byte(8'h11);
    n_tests++; if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL over_flags got error=%b busy=%b want 1 0", error, busy); end
    // Bytes after the error must not be written anywhere.
    send_byte(8'hEE); send_byte(8'hEE);
    n_tests++; if (words_loaded !== 5'd0) begin n_fail++; $display("FAIL over_words got %0d want 0", words_loaded); end
    do_read(4'd0, d);
    n_tests++; if (d !== 16'h5678) begin n_fail++; $display("FAIL over_rd0 got %h want 5678", d); end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy got %b want 1", busy); end
    send_byte(8'h00);
    n_tests++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 5'd0) begin
      n_fail++; $display("FAIL zero_result got done=%b error=%b words=%0d want 1 0 0", done, error, words_loaded); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    pulse_start();
    send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'h73);
    n_tests++; if (done !== 1'b1 || words_loaded !== 5'd1) begin
      n_fail++; $display("FAIL b2b_result got done=%b words=%0d want 1 1", done, words_loaded); end
    do_read(4'd0, d);
    n_tests++; if (d !== 16'hDEAD) begin n_fail++; $display("FAIL b2b_rd0 got %h want dead", d); end
  endtask

  task automatic test_full_depth();
    logic [DW-1:0] d;
    logic [7:0]    cs;
    cs = 8'h00;
    pulse_start();
    send_byte(8'h00); send_byte(8'h10);
    n_tests++; if (busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL full_len_ok got busy=%b error=%b want 1 0", busy, error); end
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      send_byte(8'hF0 ^ 8'(i));
      cs = cs ^ 8'(i) ^ 8'hF0 ^ 8'(i);
    end
    send_byte(cs);
    n_tests++; if (done !== 1'b1 || words_loaded !== 5'd16) begin
      n_fail++; $display("FAIL full_result got done=%b words=%0d want 1 16", done, words_loaded); end
    do_read(4'd15, d);
    n_tests++; if (d !== 16'h0FFF) begin n_fail++; $display("FAIL full_rd15 got %h want 0fff", d); end
    do_read(4'd1, d);
    n_tests++; if (d !== 16'h01F1) begin n_fail++; $display("FAIL full_rd1 got %h want 01f1", d); end
  endtask

  task automatic test_timeout();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA);
    repeat (15) @(negedge clk);
    n_tests++; if (busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL to_early got busy=%b error=%b want 1 0", busy, error); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || error !== 1'b1) begin
      n_fail++; $display("FAIL to_fire got busy=%b error=%b want 0 1", busy, error); end
    send_byte(8'hBB);
    n_tests++; if (words_loaded !== 5'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_ignore got words=%0d busy=%b want 0 0", words_loaded, busy); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk); rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h44;
    @(negedge clk); rst = 1'b0; rx_valid = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_flags got busy=%b done=%b error=%b words=%0d want 0 0 0 0",
                        busy, done, error, words_loaded); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h55);
    n_tests++; if (busy !== 1'b0 || words_loaded !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_ignore got busy=%b words=%0d want 0 0", busy, words_loaded); end
    do_read(4'd0, d);
    n_tests++; if (d !== 16'h1122) begin n_fail++; $display("FAIL rstmid_rd0 got %h want 1122", d); end
    do_read(4'd1, d);
    n_tests++; if (d !== 16'h01F1) begin n_fail++; $display("FAIL rstmid_rd1 got %h want 01f1", d); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_oversize();
    test_zero_len();
    test_back_to_back();
    test_full_depth();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
